// File: rtl/spi_shifter_pkg.sv
// ---------------------------------------------------------------------------
// spi_shifter_pkg
//   Shared definitions for the SPI byte engine and its register block:
//   FSM state encodings, the {CPOL,CPHA} bit positions inside the mode field,
//   the register map of the surrounding spi_master, and a counter-width
//   helper.
// ---------------------------------------------------------------------------
package spi_shifter_pkg;

    // Transfer FSM encodings (kept as plain constants so the register block
    // can decode the same values).
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Bit positions inside the 2-bit mode field {CPOL,CPHA}.
    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    // spi_master register map.
    localparam int REG_STATUS   = 0;
    localparam int REG_DATA_OUT = 1;
    localparam int REG_DATA_IN  = 2;
    localparam int REG_CTRL     = 3;
    localparam int CTRL_SS_BIT  = 2;

    // Width of a down-counter that must hold max_val; never less than 1 bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = (max_val < 1) ? 1 : $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_shifter_if.sv
// ---------------------------------------------------------------------------
// spi_shifter_if
//   Bundles the control handshake between spi_master and the byte engine
//   together with the SPI pad signals.
//   master modport : the surrounding logic (register block + MISO pad) that
//                    requests transfers and reads back results.
//   slave modport  : the byte engine itself.
//   Signals:
//     start   1  start request, one-cycle pulse
//     mode    2  {CPOL,CPHA}
//     tx_data 8  byte to send
//     rx_data 8  last byte received
//     busy    1  transfer in progress
//     done    1  one-cycle pulse at transfer end
//     sclk    1  SPI clock
//     mosi    1  master out slave in
//     miso    1  master in slave out
// ---------------------------------------------------------------------------
interface spi_shifter_if;
    logic       start;
    logic [1:0] mode;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       miso;

    modport master (
        output start, mode, tx_data, miso,
        input  rx_data, busy, done, sclk, mosi
    );

    modport slave (
        input  start, mode, tx_data, miso,
        output rx_data, busy, done, sclk, mosi
    );
endinterface

// File: rtl/spi_shifter_clk_div.sv
// ---------------------------------------------------------------------------
// spi_shifter_clk_div
//   Reloadable down-counter producing a one-cycle tick every HALF_DIV cycles
//   while enabled. clear reloads HALF_DIV-1 so the first tick lands exactly
//   HALF_DIV cycles after the clearing cycle.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     clear  reload the counter (transfer start)
//     en     count enable (SHIFT state only)
//     tick   SCLK half-period boundary, valid in the cycle it is high
// ---------------------------------------------------------------------------
module spi_shifter_clk_div #(
    parameter int HALF_DIV = 2,
    parameter int DIV_W    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(HALF_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;

    assign tick = en && (div_cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else if (clear) begin
            div_cnt_reg <= RELOAD;
        end else if (en) begin
            div_cnt_reg <= (div_cnt_reg == '0) ? RELOAD : div_cnt_reg - 1'b1;
        end
    end
endmodule

// File: rtl/spi_shifter.sv
// ---------------------------------------------------------------------------
// spi_shifter
//   Bit-level SPI engine: one full-duplex 8-bit byte per start, MSB first,
//   all four {CPOL,CPHA} modes. Slave select is handled by spi_master.
//   Ports:
//     clk    system clock, all state on posedge
//     rst_n  asynchronous active-low reset
//     bus    spi_shifter_if.slave (start/mode/tx_data in, rx_data/busy/done
//            out, sclk/mosi out, miso in)
//   Timing (H = HALF_DIV, T0 = start cycle): SCLK edge k registered in
//   cycle T0+k*H, done high in cycle T0+16*H+1, rx_data valid the cycle
//   after done.
// ---------------------------------------------------------------------------
module spi_shifter
    import spi_shifter_pkg::*;
#(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int SCLK_FREQ = 1_000_000
) (
    input logic          clk,
    input logic          rst_n,
    spi_shifter_if.slave bus
);
    localparam int HALF_DIV = CLK_FREQ / (2 * SCLK_FREQ);
    localparam int DIV_W    = cnt_width(HALF_DIV);

    if (HALF_DIV < 1) begin : g_div_check
        $error("spi_shifter: CLK_FREQ/(2*SCLK_FREQ) must be at least 1");
    end

    logic [1:0] state_reg;
    logic       cpha_reg;
    logic [7:0] tx_sr_reg;
    logic [7:0] rx_sr_reg;
    logic [7:0] data_reg;
    logic [4:0] edge_cnt_reg;
    logic       sclk_reg;
    logic       mosi_reg;

    logic       start_ok;
    logic       tick;
    logic [4:0] edge_num;
    logic       leading;
    logic       sample_edge;

    assign start_ok = bus.start && (state_reg == S_IDLE);
    assign edge_num = edge_cnt_reg + 5'd1;
    // Odd-numbered edges move SCLK away from CPOL (leading edges).
    assign leading  = edge_num[0];
    // CPHA=0 samples on leading edges, CPHA=1 on trailing ones.
    assign sample_edge = (leading != cpha_reg);

    spi_shifter_clk_div #(
        .HALF_DIV (HALF_DIV),
        .DIV_W    (DIV_W)
    ) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_ok),
        .en    (state_reg == S_SHIFT),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cpha_reg     <= 1'b0;
            tx_sr_reg    <= '0;
            rx_sr_reg    <= '0;
            data_reg     <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    sclk_reg <= bus.mode[CPOL_BIT];
                    if (bus.start) begin
                        state_reg    <= S_SHIFT;
                        cpha_reg     <= bus.mode[CPHA_BIT];
                        tx_sr_reg    <= bus.tx_data;
                        mosi_reg     <= bus.tx_data[7];
                        rx_sr_reg    <= '0;
                        edge_cnt_reg <= '0;
                    end
                end
                S_SHIFT: begin
                    if (tick) begin
                        sclk_reg     <= ~sclk_reg;
                        edge_cnt_reg <= edge_num;
                        if (sample_edge) begin
                            // MISO taken straight from the pin in the tick cycle.
                            rx_sr_reg <= {rx_sr_reg[6:0], bus.miso};
                        end else if (cpha_reg) begin
                            // CPHA=1 launches the current bit on leading edges.
                            mosi_reg  <= tx_sr_reg[7];
                            tx_sr_reg <= {tx_sr_reg[6:0], 1'b0};
                        end else if (edge_num != 5'd16) begin
                            // CPHA=0 already presented bit7 at start; trailing
                            // edges advance to the next bit, except the last.
                            mosi_reg  <= tx_sr_reg[6];
                            tx_sr_reg <= {tx_sr_reg[6:0], 1'b0};
                        end
                        if (edge_num == 5'd16) begin
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    data_reg  <= rx_sr_reg;
                    mosi_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.sclk    = sclk_reg;
    assign bus.mosi    = mosi_reg;
    assign bus.rx_data = data_reg;
    assign bus.busy    = (state_reg != S_IDLE);
    assign bus.done    = (state_reg == S_DONE);
endmodule

// File: tb/tb_spi_shifter.sv
// ---------------------------------------------------------------------------
// tb_spi_shifter
//   Bench for spi_shifter at HALF_DIV=2 (48 MHz / 12 MHz). A transfer-level
//   model derives SCLK/MOSI/busy/done/rx_data for every cycle from the
//   transfer's elapsed time; directed scenarios pin the model with literal
//   values, then randomized transfers run against it.
// ---------------------------------------------------------------------------
module tb_spi_shifter;
    localparam int H       = 2;
    localparam int DONE_AT = 16 * H + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_shifter_if itf ();

    spi_shifter #(
        .CLK_FREQ  (48_000_000),
        .SCLK_FREQ (12_000_000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (itf)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (itf.done === 1'b1) done_cnt++;

    // MISO sources: 0 loopback, 1 constant, 2 random per cycle, 3 slave model
    logic [1:0] miso_sel   = 2'd0;
    logic       miso_const = 1'b0;
    logic       miso_rand  = 1'b0;
    logic       miso_slave = 1'b0;
    logic       slave_en   = 1'b0;
    logic [7:0] slave_tx   = 8'h00;
    logic [7:0] slave_rx   = 8'h00;

    assign itf.miso = (miso_sel == 2'd0) ? itf.mosi :
                      (miso_sel == 2'd1) ? miso_const :
                      (miso_sel == 2'd2) ? miso_rand : miso_slave;

    always @(posedge clk) begin
        #2;
        miso_rand = 1'($urandom);
    end

    // Mode-3 slave: shifts out on falling (leading) SCLK, captures on rising.
    always @(negedge itf.sclk) if (slave_en) begin
        miso_slave = slave_tx[7];
        slave_tx   = {slave_tx[6:0], 1'b0};
    end
    always @(posedge itf.sclk) if (slave_en) slave_rx = {slave_rx[6:0], itf.mosi};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_act       = 1'b0;
    int         m_cur       = 0;     // cycle index within transfer (T0 = 0)
    logic [1:0] m_mode      = 2'b00;
    logic [7:0] m_data      = 8'h00;
    logic [7:0] m_rx        = 8'h00;
    logic [7:0] m_exp_rx    = 8'h00;
    logic       m_idle_sclk = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int k;
        if (!rst_n) begin
            m_act       = 1'b0;
            m_cur       = 0;
            m_rx        = 8'h00;
            m_exp_rx    = 8'h00;
            m_idle_sclk = 1'b0;
        end else if (!m_act) begin
            m_idle_sclk = itf.mode[1];
            if (itf.start === 1'b1) begin
                m_act  = 1'b1;
                m_mode = itf.mode;
                m_data = itf.tx_data;
                m_rx   = 8'h00;
                m_cur  = 1;
            end
        end else begin
            k = m_cur / H;
            if ((m_cur % H == 0) && k >= 1 && k <= 16) begin
                // leading edge = odd k; CPHA=0 samples leading, CPHA=1 trailing
                if ((k % 2 == 1) == (m_mode[0] == 1'b0))
                    m_rx = {m_rx[6:0], itf.miso};
            end
            if (m_cur == DONE_AT) begin
                m_act       = 1'b0;
                m_exp_rx    = m_rx;
                m_idle_sclk = m_mode[1];
            end
            m_cur++;
        end
    end

    always @(negedge clk) begin
        int   e, j;
        logic sclk_e, mosi_e, busy_e, done_e;
        if (m_act) begin
            e = (m_cur - 1) / H;
            if (e > 16) e = 16;
            sclk_e = m_mode[1] ^ e[0];
            if (m_mode[0] == 1'b0) j = e / 2;
            else                   j = (e == 0) ? 0 : (e - 1) / 2;
            if (j > 7) j = 7;
            mosi_e = m_data[7 - j];
            busy_e = 1'b1;
            done_e = (m_cur == DONE_AT);
        end else begin
            sclk_e = m_idle_sclk;
            mosi_e = 1'b0;
            busy_e = 1'b0;
            done_e = 1'b0;
        end
        chk("sclk",    itf.sclk,    sclk_e);
        chk("mosi",    itf.mosi,    mosi_e);
        chk("busy",    itf.busy,    busy_e);
        chk("done",    itf.done,    done_e);
        chk("rx_data", itf.rx_data, m_exp_rx);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_mode(input logic [1:0] m);
        @(posedge clk); #1;
        itf.mode = m;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [7:0] d, output int t0);
        @(posedge clk); #1;
        itf.start   = 1'b1;
        itf.mode    = m;
        itf.tx_data = d;
        t0 = cyc;
        @(posedge clk); #1;
        itf.start = 1'b0;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (itf.done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        int t0, t1, td, d1, d2, dc0, gap;
        logic [1:0] m;
        logic [7:0] d;
        logic [1:0] sel;

        itf.start   = 1'b0;
        itf.mode    = 2'b00;
        itf.tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("reset_rx_data", itf.rx_data, 8'h00);
        chk("reset_busy",    itf.busy,    1'b0);
        chk("reset_sclk",    itf.sclk,    1'b0);

        // 1. mode 0 loopback
        set_mode(2'b00);
        miso_sel = 2'd0;
        pulse_start(2'b00, 8'hA5, t0);
        wait_done(td);
        chk("t1_latency", td - t0, 33);
        next_cycle();
        chk("t1_rx", itf.rx_data, 8'hA5);

        // 2. mode 3 with slave returning 0x3C
        set_mode(2'b11);
        slave_tx = 8'h3C;
        slave_rx = 8'h00;
        miso_sel = 2'd3;
        slave_en = 1'b1;
        pulse_start(2'b11, 8'hC3, t0);
        wait_done(td);
        chk("t2_sclk_end", itf.sclk, 1'b1);
        next_cycle();
        slave_en = 1'b0;
        chk("t2_rx", itf.rx_data, 8'h3C);
        chk("t2_slave_rx", slave_rx, 8'hC3);

        // 3. modes 1 and 2, MISO held high, all-zero data
        miso_sel   = 2'd1;
        miso_const = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            set_mode(2'(i));
            pulse_start(2'(i), 8'h00, t0);
            wait_done(td);
            next_cycle();
            chk("t3_rx", itf.rx_data, 8'hFF);
        end

        // 4. ignored re-start mid-transfer
        set_mode(2'b00);
        miso_sel = 2'd0;
        dc0 = done_cnt;
        pulse_start(2'b00, 8'h6B, t0);
        repeat (9) @(posedge clk);
        #1;
        itf.start   = 1'b1;
        itf.tx_data = 8'h11;
        itf.mode    = 2'b11;
        @(posedge clk); #1;
        itf.start = 1'b0;
        wait_done(td);
        chk("t4_latency", td - t0, 33);
        repeat (5) next_cycle();
        chk("t4_done_count", done_cnt - dc0, 1);
        chk("t4_rx", itf.rx_data, 8'h6B);

        // 5. reset mid-transfer
        set_mode(2'b00);
        dc0 = done_cnt;
        pulse_start(2'b00, 8'h77, t0);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", itf.busy, 1'b0);
        chk("t5_sclk", itf.sclk, 1'b0);
        chk("t5_mosi", itf.mosi, 1'b0);
        chk("t5_rx",   itf.rx_data, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t5_no_done", done_cnt - dc0, 0);
        set_mode(2'b10);
        pulse_start(2'b10, 8'h3E, t0);
        wait_done(td);
        chk("t5_latency", td - t0, 33);
        next_cycle();
        chk("t5_rx_after", itf.rx_data, 8'h3E);

        // 6. back-to-back
        set_mode(2'b00);
        pulse_start(2'b00, 8'h5A, t0);
        wait_done(d1);
        pulse_start(2'b00, 8'h96, t1);
        chk("t6_start_gap", t1 - d1, 1);
        chk("t6_rx1", itf.rx_data, 8'h5A);
        wait_done(d2);
        chk("t6_done_spacing", d2 - d1, 34);
        next_cycle();
        chk("t6_rx2", itf.rx_data, 8'h96);

        // randomized transfers
        for (int i = 0; i < 40; i++) begin
            m   = 2'($urandom_range(0, 3));
            d   = 8'($urandom);
            sel = 2'($urandom_range(0, 2));
            miso_const = 1'($urandom);
            miso_sel   = sel;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                itf.mode = 2'($urandom_range(0, 3));
                repeat (gap) @(posedge clk);
                #1;
            end
            pulse_start(m, d, t0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #1;
                itf.start   = 1'b1;
                itf.tx_data = 8'($urandom);
                itf.mode    = 2'($urandom_range(0, 3));
                @(posedge clk); #1;
                itf.start = 1'b0;
            end
            wait_done(td);
            chk("rand_latency", td - t0, 33);
            if (sel == 2'd0) begin
                next_cycle();
                chk("rand_loopback_rx", itf.rx_data, {24'd0, d});
            end
        end

        repeat (4) next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end
endmodule
